// File: rtl/alu_op_issue_if.sv
// Handshake bundle between the decode issue stage, its upstream fetch/decode
// and the downstream execute stage.
interface alu_op_issue_if #(
   parameter int OPCODE_LENGTH = 4,
   parameter int TAG_WIDTH     = 5,
   parameter int CNT_WIDTH     = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [1:0]               in_aluop;
   logic [2:0]               in_funct3;
   logic [6:0]               in_funct7;
   logic [TAG_WIDTH-1:0]     in_tag;
   logic                     out_valid;
   logic                     out_ready;
   logic [OPCODE_LENGTH-1:0] out_op;
   logic                     out_br_inv;
   logic                     out_illegal;
   logic [TAG_WIDTH-1:0]     out_tag;
   logic [CNT_WIDTH-1:0]     illegal_cnt;

   modport master (
      output in_valid, in_aluop, in_funct3, in_funct7, in_tag, out_ready,
      input  in_ready, out_valid, out_op, out_br_inv, out_illegal, out_tag, illegal_cnt
   );

   modport slave (
      input  in_valid, in_aluop, in_funct3, in_funct7, in_tag, out_ready,
      output in_ready, out_valid, out_op, out_br_inv, out_illegal, out_tag, illegal_cnt
   );
endinterface

// File: rtl/alu_op_issue.sv
// ALU decode/issue stage: ALUOp/funct3/funct7 -> ALU Operation code, registered
// through a main register plus one skid register, with a saturating illegal-op counter.
module alu_op_issue #(
   parameter int OPCODE_LENGTH = 4,
   parameter int TAG_WIDTH     = 5,
   parameter int CNT_WIDTH     = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_op_issue_if.slave  bus
);

   typedef struct packed {
      logic                     illegal;
      logic                     br_inv;
      logic [OPCODE_LENGTH-1:0] op;
      logic [TAG_WIDTH-1:0]     tag;
   } entry_t;

   localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
   localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
   localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b1001);
   localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1100);
   localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

   localparam entry_t ENTRY_RST = '{illegal: 1'b0, br_inv: 1'b0, op: OP_ADD,
                                    tag: {TAG_WIDTH{1'b0}}};

   function automatic entry_t decode(input logic [1:0] aluop, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [TAG_WIDTH-1:0] tag);
      entry_t e;
      logic   z;
      logic   alt;
      z         = (f7 == 7'b0000000);
      alt       = (f7 == 7'b0100000);
      e.illegal = 1'b0;
      e.br_inv  = 1'b0;
      e.op      = OP_ADD;
      e.tag     = tag;
      case (aluop)
         2'b00: e.op = OP_ADD;
         2'b01: begin
            case (f3)
               3'b000:  e.op = OP_EQ;
               3'b001:  begin e.op = OP_EQ; e.br_inv = 1'b1; end
               3'b100:  e.op = OP_LT;
               default: e.illegal = 1'b1;
            endcase
         end
         2'b10: begin
            // R-type: only the SUB/SRA alternate funct7 is tolerated besides zero
            case (f3)
               3'b000:  if (z) e.op = OP_ADD; else if (alt) e.op = OP_SUB; else e.illegal = 1'b1;
               3'b101:  if (z) e.op = OP_SRL; else if (alt) e.op = OP_SRA; else e.illegal = 1'b1;
               3'b111:  if (z) e.op = OP_AND; else e.illegal = 1'b1;
               3'b110:  if (z) e.op = OP_OR;  else e.illegal = 1'b1;
               3'b100:  if (z) e.op = OP_XOR; else e.illegal = 1'b1;
               3'b010:  if (z) e.op = OP_LT;  else e.illegal = 1'b1;
               3'b001:  if (z) e.op = OP_SLL; else e.illegal = 1'b1;
               default: e.illegal = 1'b1;
            endcase
         end
         2'b11: begin
            case (f3)
               3'b000:  e.op = OP_ADD;
               3'b111:  e.op = OP_AND;
               3'b110:  e.op = OP_OR;
               3'b100:  e.op = OP_XOR;
               3'b010:  e.op = OP_LT;
               3'b001:  if (z) e.op = OP_SLL; else e.illegal = 1'b1;
               3'b101:  if (z) e.op = OP_SRL; else if (alt) e.op = OP_SRA; else e.illegal = 1'b1;
               default: e.illegal = 1'b1;
            endcase
         end
         default: e.illegal = 1'b1;
      endcase
      e.op     = e.illegal ? OP_ILL : e.op;
      e.br_inv = e.br_inv & ~e.illegal;
      return e;
   endfunction

   entry_t               r_m;
   entry_t               r_s;
   logic                 r_m_valid;
   logic                 r_s_valid;
   logic [CNT_WIDTH-1:0] r_cnt;

   entry_t               w_dec;
   logic                 w_accept;
   logic                 w_consume;

   assign w_dec     = decode(bus.in_aluop, bus.in_funct3, bus.in_funct7, bus.in_tag);
   assign w_accept  = bus.in_valid & ~r_s_valid;
   assign w_consume = r_m_valid & bus.out_ready;

   // Main/skid storage: the skid entry always drains into main before new input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m       <= ENTRY_RST;
         r_s       <= ENTRY_RST;
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
      end else if (w_consume) begin
         if (r_s_valid) begin
            r_m       <= r_s;
            r_s_valid <= 1'b0;
         end else if (w_accept) begin
            r_m       <= w_dec;
         end else begin
            r_m_valid <= 1'b0;
         end
      end else if (!r_m_valid) begin
         if (w_accept) begin
            r_m       <= w_dec;
            r_m_valid <= 1'b1;
         end else begin
            r_m_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_s       <= w_dec;
         r_s_valid <= 1'b1;
      end else begin
         r_s_valid <= r_s_valid;
      end
   end

   // Saturating count of accepted illegal ops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CNT_WIDTH{1'b0}};
      end else if (w_accept && w_dec.illegal && (r_cnt != {CNT_WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign bus.in_ready    = ~r_s_valid;
   assign bus.out_valid   = r_m_valid;
   assign bus.out_op      = r_m.op;
   assign bus.out_br_inv  = r_m.br_inv;
   assign bus.out_illegal = r_m.illegal;
   assign bus.out_tag     = r_m.tag;
   assign bus.illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized and directed bench for alu_op_issue; a table-driven decoder plus a
// FIFO queue stand in for the stage.
module tb_alu_op_issue;

   localparam int R_ILL  = 0;
   localparam int R_ANY  = 1;
   localparam int R_ZERO = 2;
   localparam int R_ALT  = 3;

   typedef struct {
      logic [3:0] op;
      logic       br;
      logic       ill;
      logic [4:0] tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   m_cnt;
   exp_t q[$];

   logic [3:0] t_op[32];
   logic [3:0] t_alt[32];
   int         t_rule[32];
   logic       t_br[32];

   alu_op_issue_if #(.OPCODE_LENGTH(4), .TAG_WIDTH(5), .CNT_WIDTH(8)) bus ();

   alu_op_issue #(.OPCODE_LENGTH(4), .TAG_WIDTH(5), .CNT_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_row(input logic [1:0] a, input logic [2:0] f3, input int rule,
                          input logic [3:0] op, input logic [3:0] alt, input logic br);
      int i;
      i         = int'({a, f3});
      t_rule[i] = rule;
      t_op[i]   = op;
      t_alt[i]  = alt;
      t_br[i]   = br;
   endtask

   task automatic build_table();
      for (int i = 0; i < 32; i++) begin
         t_rule[i] = R_ILL; t_op[i] = 4'hF; t_alt[i] = 4'hF; t_br[i] = 1'b0;
      end
      for (int f = 0; f < 8; f++) set_row(2'b00, 3'(f), R_ANY, 4'b0010, 4'hF, 1'b0);
      set_row(2'b01, 3'b000, R_ANY,  4'b1000, 4'hF,    1'b0);
      set_row(2'b01, 3'b001, R_ANY,  4'b1000, 4'hF,    1'b1);
      set_row(2'b01, 3'b100, R_ANY,  4'b1100, 4'hF,    1'b0);
      set_row(2'b10, 3'b000, R_ALT,  4'b0010, 4'b0011, 1'b0);
      set_row(2'b10, 3'b101, R_ALT,  4'b0101, 4'b0111, 1'b0);
      set_row(2'b10, 3'b111, R_ZERO, 4'b0000, 4'hF,    1'b0);
      set_row(2'b10, 3'b110, R_ZERO, 4'b0001, 4'hF,    1'b0);
      set_row(2'b10, 3'b100, R_ZERO, 4'b1001, 4'hF,    1'b0);
      set_row(2'b10, 3'b010, R_ZERO, 4'b1100, 4'hF,    1'b0);
      set_row(2'b10, 3'b001, R_ZERO, 4'b0100, 4'hF,    1'b0);
      set_row(2'b11, 3'b000, R_ANY,  4'b0010, 4'hF,    1'b0);
      set_row(2'b11, 3'b111, R_ANY,  4'b0000, 4'hF,    1'b0);
      set_row(2'b11, 3'b110, R_ANY,  4'b0001, 4'hF,    1'b0);
      set_row(2'b11, 3'b100, R_ANY,  4'b1001, 4'hF,    1'b0);
      set_row(2'b11, 3'b010, R_ANY,  4'b1100, 4'hF,    1'b0);
      set_row(2'b11, 3'b001, R_ZERO, 4'b0100, 4'hF,    1'b0);
      set_row(2'b11, 3'b101, R_ALT,  4'b0101, 4'b0111, 1'b0);
   endtask

   function automatic exp_t ref_decode(input logic [1:0] a, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [4:0] tag);
      exp_t e;
      int   i;
      i     = int'({a, f3});
      e.tag = tag;
      e.br  = t_br[i];
      e.ill = 1'b0;
      e.op  = t_op[i];
      case (t_rule[i])
         R_ANY:   e.ill = 1'b0;
         R_ZERO:  e.ill = (f7 != 7'd0);
         R_ALT: begin
            if (f7 == 7'b0100000) e.op = t_alt[i];
            else if (f7 != 7'd0)  e.ill = 1'b1;
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) begin
         e.op = 4'hF;
         e.br = 1'b0;
      end
      return e;
   endfunction

   // Called at a falling edge: drive, compare against the model, advance the model, step one cycle.
   task automatic cycle(input logic v, input logic [1:0] a, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] tag, input logic ordy);
      exp_t e;
      logic m_acc;
      logic m_con;
      bus.in_valid  = v;
      bus.in_aluop  = a;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_tag    = tag;
      bus.out_ready = ordy;
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(m_cnt));
      if (q.size() > 0) begin
         chk("out_op", 32'(bus.out_op), 32'(q[0].op));
         chk("out_br_inv", 32'(bus.out_br_inv), 32'(q[0].br));
         chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
         chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
      end
      e     = ref_decode(a, f3, f7, tag);
      m_acc = v && (q.size() < 2);
      m_con = (q.size() > 0) && ordy;
      if (m_con) void'(q.pop_front());
      if (m_acc) begin
         q.push_back(e);
         if (e.ill && m_cnt < 255) m_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 2'b00, 3'b000, 7'd0, 5'd0, ordy);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_cnt  = 0;
      build_table();
      bus.in_valid = 1'b0; bus.in_aluop = 2'b00; bus.in_funct3 = 3'b000;
      bus.in_funct7 = 7'd0; bus.in_tag = 5'd0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_op", 32'(bus.out_op), 32'h2);
      chk("rst_br_inv", 32'(bus.out_br_inv), 32'd0);
      chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
      chk("rst_tag", 32'(bus.out_tag), 32'd0);
      chk("rst_cnt", 32'(bus.illegal_cnt), 32'd0);
      @(negedge clk);

      // R-type SUB with one-cycle latency
      cycle(1'b1, 2'b10, 3'b000, 7'b0100000, 5'd3, 1'b1);
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_op", 32'(bus.out_op), 32'h3);
      chk("t1_tag", 32'(bus.out_tag), 32'd3);

      // Branch decodes
      cycle(1'b1, 2'b01, 3'b001, 7'd0, 5'd4, 1'b1);
      chk("t2_bne_op", 32'(bus.out_op), 32'h8);
      chk("t2_bne_inv", 32'(bus.out_br_inv), 32'd1);
      cycle(1'b1, 2'b01, 3'b100, 7'd0, 5'd5, 1'b1);
      chk("t2_lt_op", 32'(bus.out_op), 32'hC);
      chk("t2_lt_inv", 32'(bus.out_br_inv), 32'd0);
      cycle(1'b1, 2'b01, 3'b010, 7'd0, 5'd6, 1'b1);
      chk("t2_ill_flag", 32'(bus.out_illegal), 32'd1);
      chk("t2_ill_op", 32'(bus.out_op), 32'hF);
      chk("t2_ill_cnt", 32'(bus.illegal_cnt), 32'd1);

      // Shift decodes
      cycle(1'b1, 2'b11, 3'b101, 7'b0100000, 5'd7, 1'b1);
      chk("t4_sra", 32'(bus.out_op), 32'h7);
      cycle(1'b1, 2'b11, 3'b101, 7'b0000001, 5'd8, 1'b1);
      chk("t4_ill", 32'(bus.out_illegal), 32'd1);
      cycle(1'b1, 2'b10, 3'b001, 7'd0, 5'd9, 1'b1);
      chk("t4_sll", 32'(bus.out_op), 32'h4);
      idle(1'b1);

      // Backpressure fills main and skid, then drains in order
      cycle(1'b1, 2'b00, 3'b000, 7'd0, 5'd1, 1'b0);
      cycle(1'b1, 2'b00, 3'b000, 7'd0, 5'd2, 1'b0);
      chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t3_first", 32'(bus.out_tag), 32'd1);
      idle(1'b1);
      chk("t3_second_v", 32'(bus.out_valid), 32'd1);
      chk("t3_second", 32'(bus.out_tag), 32'd2);
      idle(1'b1);
      chk("t3_drained", 32'(bus.out_valid), 32'd0);

      for (int n = 0; n < 600; n++) begin
         logic [6:0] f7;
         case ($urandom_range(0, 2))
            0:       f7 = 7'd0;
            1:       f7 = 7'b0100000;
            default: f7 = 7'($urandom);
         endcase
         cycle(1'($urandom_range(0, 9) < 7), 2'($urandom), 3'($urandom), f7,
               5'($urandom), 1'($urandom_range(0, 9) < 6));
      end

      // Counter saturation
      for (int n = 0; n < 300; n++) cycle(1'b1, 2'b01, 3'b010, 7'd0, 5'(n), 1'b1);
      chk("t5_saturate", 32'(bus.illegal_cnt), 32'd255);

      // Asynchronous reset with both registers occupied
      idle(1'b1);
      idle(1'b1);
      cycle(1'b1, 2'b10, 3'b011, 7'd0, 5'd10, 1'b0);
      cycle(1'b1, 2'b10, 3'b011, 7'd0, 5'd11, 1'b0);
      chk("t6_full", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_rst_cnt", 32'(bus.illegal_cnt), 32'd0);
      q.delete();
      m_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      cycle(1'b1, 2'b10, 3'b100, 7'd0, 5'd12, 1'b1);
      chk("t6_after_op", 32'(bus.out_op), 32'h9);
      idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
